// File: rtl/ti_link_pkg.sv
// Shared definitions for the TI-link responder: command IDs, parser states
// and the command classification helpers.
package ti_link_pkg;

    localparam logic [7:0] CMD_VAR  = 8'h06;
    localparam logic [7:0] CMD_DATA = 8'h15;
    localparam logic [7:0] CMD_SKIP = 8'h36;
    localparam logic [7:0] CMD_ACK  = 8'h56;
    localparam logic [7:0] CMD_ERR  = 8'h5A;
    localparam logic [7:0] CMD_RDY  = 8'h68;
    localparam logic [7:0] CMD_DEL  = 8'h88;
    localparam logic [7:0] CMD_EOT  = 8'h92;
    localparam logic [7:0] CMD_REQ  = 8'hA2;
    localparam logic [7:0] CMD_RTS  = 8'hC9;

    typedef enum logic [2:0] {
        S_MID   = 3'd0,
        S_CMD   = 3'd1,
        S_LENL  = 3'd2,
        S_LENH  = 3'd3,
        S_DATA  = 3'd4,
        S_CSL   = 3'd5,
        S_CSH   = 3'd6,
        S_REPLY = 3'd7
    } state_t;

    // Commands that carry LEN payload bytes plus a checksum (when LEN is non-zero).
    function automatic logic has_payload(input logic [7:0] cmd);
        case (cmd)
            CMD_VAR, CMD_DATA, CMD_SKIP, CMD_DEL, CMD_REQ, CMD_RTS: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // Bare (payload-less) commands that still expect an ACK from the device.
    function automatic logic acks_bare(input logic [7:0] cmd);
        return (cmd == CMD_RDY) || (cmd == CMD_EOT);
    endfunction

endpackage

// File: rtl/ti_link_reply_tx.sv
// Four-byte reply sequencer: sends {MID, cmd, 00, 00} over the dbus
// enable/busy handshake, one byte per handshake, then pulses o_done.
module ti_link_reply_tx
    import ti_link_pkg::*;
#(
    parameter logic [7:0] c_REPLYMID = 8'h73
) (
    input  logic       i_clock,
    input  logic       i_reset_n,
    input  logic       i_start,
    input  logic [7:0] i_cmd,
    input  logic       i_txbusy,
    output logic [7:0] o_txdata,
    output logic       o_txenable,
    output logic       o_done
);

    logic       active_q, active_d;
    logic [1:0] idx_q, idx_d;
    logic [7:0] cmd_q, cmd_d;
    logic [7:0] txdata_q, txdata_d;
    logic       txen_q, txen_d;
    logic       done_q, done_d;
    logic [7:0] byte_sel;

    // Next-state logic: raise enable only when the bus is idle, drop it once busy is seen.
    always_comb begin
        active_d = active_q;
        idx_d    = idx_q;
        cmd_d    = cmd_q;
        txdata_d = txdata_q;
        txen_d   = txen_q;
        done_d   = 1'b0;
        case (idx_q)
            2'd0:    byte_sel = c_REPLYMID;
            2'd1:    byte_sel = cmd_q;
            default: byte_sel = 8'h00;
        endcase
        if (i_start && !active_q) begin
            active_d = 1'b1;
            idx_d    = 2'd0;
            cmd_d    = i_cmd;
        end else if (active_q) begin
            if (!txen_q && !i_txbusy) begin
                txen_d   = 1'b1;
                txdata_d = byte_sel;
            end else if (txen_q && i_txbusy) begin
                txen_d = 1'b0;
                if (idx_q == 2'd3) begin
                    active_d = 1'b0;
                    done_d   = 1'b1;
                end else begin
                    idx_d = idx_q + 2'd1;
                end
            end
        end
    end

    // State and output registers; reset drops the enable immediately.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            active_q <= 1'b0;
            idx_q    <= 2'd0;
            cmd_q    <= 8'h00;
            txdata_q <= 8'h00;
            txen_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            active_q <= active_d;
            idx_q    <= idx_d;
            cmd_q    <= cmd_d;
            txdata_q <= txdata_d;
            txen_q   <= txen_d;
            done_q   <= done_d;
        end
    end

    assign o_txdata   = txdata_q;
    assign o_txenable = txen_q;
    assign o_done     = done_q;

endmodule

// File: rtl/ti_link_responder.sv
// TI-link device-side packet engine: parses packets from dbus, forwards
// payload bytes, verifies the checksum and answers with ACK/ERR.
//
// state   | meaning
// S_MID   | waiting for machine ID (any value accepted)
// S_CMD   | waiting for command ID
// S_LENL  | waiting for length low byte
// S_LENH  | waiting for length high byte; decides payload / reply / done
// S_DATA  | receiving payload bytes, counter runs LEN down to 0
// S_CSL   | waiting for checksum low byte
// S_CSH   | waiting for checksum high byte; compares against accumulator
// S_REPLY | reply sequencer busy; no bytes consumed
module ti_link_responder
    import ti_link_pkg::*;
#(
    parameter logic [7:0]  c_REPLYMID = 8'h73,
    parameter logic [23:0] c_TIMEOUT  = 24'd4800000
) (
    input  logic        i_clock,
    input  logic        i_reset_n,
    input  logic [7:0]  i_rxdata,
    input  logic        i_rxavail,
    output logic        o_rxread,
    output logic [7:0]  o_txdata,
    output logic        o_txenable,
    input  logic        i_txbusy,
    output logic [7:0]  o_byte,
    output logic        o_bytevalid,
    output logic [7:0]  o_cmd,
    output logic [15:0] o_len,
    output logic        o_pktdone,
    output logic        o_csumerr,
    output logic        o_timeout
);

    state_t      state_q, state_d;
    logic        rxread_q, rxread_d;
    logic [7:0]  cmd_q, cmd_d;
    logic [15:0] len_q, len_d;
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] acc_q, acc_d;
    logic [7:0]  csl_q, csl_d;
    logic [23:0] to_cnt_q, to_cnt_d;
    logic [7:0]  byte_q, byte_d;
    logic        bytevalid_q, bytevalid_d;
    logic [7:0]  ocmd_q, ocmd_d;
    logic [15:0] olen_q, olen_d;
    logic        pktdone_q, pktdone_d;
    logic        csumerr_q, csumerr_d;
    logic        timeout_q, timeout_d;
    logic        tx_start_q, tx_start_d;
    logic [7:0]  tx_cmd_q, tx_cmd_d;
    logic        take;
    logic        tx_done;
    logic        counting;
    logic [15:0] len_rx;

    assign len_rx   = {i_rxdata, len_q[7:0]};
    assign counting = (state_q != S_MID) && (state_q != S_REPLY);

    // Parser next-state: 4-phase byte capture, packet decode, timeout abandon.
    always_comb begin
        state_d     = state_q;
        rxread_d    = rxread_q;
        cmd_d       = cmd_q;
        len_d       = len_q;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        csl_d       = csl_q;
        to_cnt_d    = to_cnt_q;
        byte_d      = byte_q;
        bytevalid_d = 1'b0;
        ocmd_d      = ocmd_q;
        olen_d      = olen_q;
        pktdone_d   = 1'b0;
        csumerr_d   = 1'b0;
        timeout_d   = 1'b0;
        tx_start_d  = 1'b0;
        tx_cmd_d    = tx_cmd_q;
        take        = 1'b0;

        // A handshake still open at reply entry may finish; no new byte is taken.
        if (rxread_q && !i_rxavail) begin
            rxread_d = 1'b0;
        end
        if ((state_q != S_REPLY) && i_rxavail && !rxread_q) begin
            take     = 1'b1;
            rxread_d = 1'b1;
        end

        if (take) begin
            to_cnt_d = 24'd0;
        end else if (counting) begin
            to_cnt_d = to_cnt_q + 24'd1;
        end

        if (take) begin
            case (state_q)
                S_MID: begin
                    acc_d   = 16'h0000;
                    state_d = S_CMD;
                end
                S_CMD: begin
                    cmd_d   = i_rxdata;
                    state_d = S_LENL;
                end
                S_LENL: begin
                    len_d   = {8'h00, i_rxdata};
                    state_d = S_LENH;
                end
                S_LENH: begin
                    len_d = len_rx;
                    if (has_payload(cmd_q) && (len_rx != 16'h0000)) begin
                        cnt_d   = len_rx;
                        state_d = S_DATA;
                    end else begin
                        pktdone_d = 1'b1;
                        ocmd_d    = cmd_q;
                        olen_d    = len_rx;
                        if (acks_bare(cmd_q)) begin
                            tx_start_d = 1'b1;
                            tx_cmd_d   = CMD_ACK;
                            state_d    = S_REPLY;
                        end else begin
                            state_d = S_MID;
                        end
                    end
                end
                S_DATA: begin
                    acc_d       = acc_q + {8'h00, i_rxdata};
                    byte_d      = i_rxdata;
                    bytevalid_d = 1'b1;
                    cnt_d       = cnt_q - 16'd1;
                    if (cnt_q == 16'd1) begin
                        state_d = S_CSL;
                    end
                end
                S_CSL: begin
                    csl_d   = i_rxdata;
                    state_d = S_CSH;
                end
                S_CSH: begin
                    ocmd_d     = cmd_q;
                    olen_d     = len_q;
                    tx_start_d = 1'b1;
                    state_d    = S_REPLY;
                    if ({i_rxdata, csl_q} == acc_q) begin
                        pktdone_d = 1'b1;
                        tx_cmd_d  = CMD_ACK;
                    end else begin
                        csumerr_d = 1'b1;
                        tx_cmd_d  = CMD_ERR;
                    end
                end
                default: ;
            endcase
        end else if (counting && (c_TIMEOUT != 24'd0) && (to_cnt_d == c_TIMEOUT)) begin
            timeout_d = 1'b1;
            acc_d     = 16'h0000;
            to_cnt_d  = 24'd0;
            state_d   = S_MID;
        end else if ((state_q == S_REPLY) && tx_done) begin
            state_d = S_MID;
        end
    end

    // Parser registers; every output is a flop and clears asynchronously.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q     <= S_MID;
            rxread_q    <= 1'b0;
            cmd_q       <= 8'h00;
            len_q       <= 16'h0000;
            cnt_q       <= 16'h0000;
            acc_q       <= 16'h0000;
            csl_q       <= 8'h00;
            to_cnt_q    <= 24'd0;
            byte_q      <= 8'h00;
            bytevalid_q <= 1'b0;
            ocmd_q      <= 8'h00;
            olen_q      <= 16'h0000;
            pktdone_q   <= 1'b0;
            csumerr_q   <= 1'b0;
            timeout_q   <= 1'b0;
            tx_start_q  <= 1'b0;
            tx_cmd_q    <= 8'h00;
        end else begin
            state_q     <= state_d;
            rxread_q    <= rxread_d;
            cmd_q       <= cmd_d;
            len_q       <= len_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            csl_q       <= csl_d;
            to_cnt_q    <= to_cnt_d;
            byte_q      <= byte_d;
            bytevalid_q <= bytevalid_d;
            ocmd_q      <= ocmd_d;
            olen_q      <= olen_d;
            pktdone_q   <= pktdone_d;
            csumerr_q   <= csumerr_d;
            timeout_q   <= timeout_d;
            tx_start_q  <= tx_start_d;
            tx_cmd_q    <= tx_cmd_d;
        end
    end

    ti_link_reply_tx #(
        .c_REPLYMID (c_REPLYMID)
    ) u_reply_tx (
        .i_clock    (i_clock),
        .i_reset_n  (i_reset_n),
        .i_start    (tx_start_q),
        .i_cmd      (tx_cmd_q),
        .i_txbusy   (i_txbusy),
        .o_txdata   (o_txdata),
        .o_txenable (o_txenable),
        .o_done     (tx_done)
    );

    assign o_rxread    = rxread_q;
    assign o_byte      = byte_q;
    assign o_bytevalid = bytevalid_q;
    assign o_cmd       = ocmd_q;
    assign o_len       = olen_q;
    assign o_pktdone   = pktdone_q;
    assign o_csumerr   = csumerr_q;
    assign o_timeout   = timeout_q;

endmodule

// File: tb/tb_ti_link_responder.sv
// Bench for ti_link_responder: table of whole packets with expected strobes
// and replies, plus timeout, busy-stall and async-reset sequences.
module tb_ti_link_responder;

    logic        clk;
    logic        i_reset_n;
    logic [7:0]  i_rxdata;
    logic        i_rxavail;
    logic        o_rxread;
    logic [7:0]  o_txdata;
    logic        o_txenable;
    logic        i_txbusy;
    logic [7:0]  o_byte;
    logic        o_bytevalid;
    logic [7:0]  o_cmd;
    logic [15:0] o_len;
    logic        o_pktdone;
    logic        o_csumerr;
    logic        o_timeout;

    ti_link_responder #(
        .c_REPLYMID (8'h73),
        .c_TIMEOUT  (24'd100)
    ) dut (
        .i_clock     (clk),
        .i_reset_n   (i_reset_n),
        .i_rxdata    (i_rxdata),
        .i_rxavail   (i_rxavail),
        .o_rxread    (o_rxread),
        .o_txdata    (o_txdata),
        .o_txenable  (o_txenable),
        .i_txbusy    (i_txbusy),
        .o_byte      (o_byte),
        .o_bytevalid (o_bytevalid),
        .o_cmd       (o_cmd),
        .o_len       (o_len),
        .o_pktdone   (o_pktdone),
        .o_csumerr   (o_csumerr),
        .o_timeout   (o_timeout)
    );

    typedef struct {
        logic [0:11][7:0] pkt;
        int               nb;
        bit               exp_done;
        bit               exp_cerr;
        logic [7:0]       exp_cmd;
        logic [15:0]      exp_len;
        int               exp_nval;
        logic [7:0]       exp_rep;   // 0 = no reply expected
    } vec_t;

    vec_t vec [11];

    int n_chk = 0;
    int n_err = 0;
    int cyc = 0;

    logic [7:0]  rx_bytes [$];
    logic [7:0]  tx_q [$];
    int          n_done, n_cerr, n_to;
    int          done_cyc, to_cyc, cap_cyc, push_cyc, rd_cyc;
    logic [7:0]  done_cmd;
    logic [15:0] done_len;
    bit          hold_busy = 1'b0;
    bit          watch_rx = 1'b0;
    int          n_en_hold = 0;
    int          n_rd_early = 0;
    int          sink_cnt = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // dbus transmit side: accept a byte on enable, stay busy for a few cycles
    initial begin
        i_txbusy = 1'b0;
        forever begin
            @(negedge clk);
            if (hold_busy) begin
                i_txbusy = 1'b1;
            end else if (sink_cnt > 0) begin
                sink_cnt--;
                if (sink_cnt == 0) i_txbusy = 1'b0;
            end else if (o_txenable) begin
                tx_q.push_back(o_txdata);
                push_cyc = cyc;
                i_txbusy = 1'b1;
                sink_cnt = 3;
            end else begin
                i_txbusy = 1'b0;
            end
        end
    end

    // strobe monitor
    initial begin
        forever begin
            @(negedge clk);
            if (o_bytevalid) rx_bytes.push_back(o_byte);
            if (o_pktdone) begin
                n_done++; done_cyc = cyc; done_cmd = o_cmd; done_len = o_len;
            end
            if (o_csumerr) begin
                n_cerr++; done_cyc = cyc; done_cmd = o_cmd; done_len = o_len;
            end
            if (o_timeout) begin
                n_to++; to_cyc = cyc;
            end
            if (hold_busy && o_txenable) n_en_hold++;
            if (watch_rx && o_rxread) begin
                if (tx_q.size() < 4) n_rd_early++;
                else if (rd_cyc < 0) rd_cyc = cyc;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clear_obs();
        n_done = 0; n_cerr = 0; n_to = 0;
        done_cyc = -1; to_cyc = -1; rd_cyc = -1;
        rx_bytes.delete();
        tx_q.delete();
    endtask

    task automatic send_byte(input logic [7:0] b);
        int k;
        @(negedge clk);
        i_rxdata  = b;
        i_rxavail = 1'b1;
        k = 0;
        while (!o_rxread && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk("rx_read_rise", {31'd0, o_rxread}, 32'd1);
        cap_cyc   = cyc;
        i_rxavail = 1'b0;
        k = 0;
        while (o_rxread && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk("rx_read_fall", {31'd0, o_rxread}, 32'd0);
    endtask

    task automatic wait_reply(input int n);
        int k;
        k = 0;
        while (tx_q.size() < n && k < 400) begin
            @(negedge clk);
            k++;
        end
    endtask

    task automatic chk_reply(input string tag, input logic [7:0] rep);
        logic [7:0] er [4];
        er[0] = 8'h73; er[1] = rep; er[2] = 8'h00; er[3] = 8'h00;
        chk($sformatf("%s_reply_len", tag), tx_q.size(), 4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("%s_reply_b%0d", tag, i),
                (i < tx_q.size()) ? {24'd0, tx_q[i]} : 32'hDEAD, {24'd0, er[i]});
        end
    endtask

    task automatic run_vec(input int v);
        clear_obs();
        for (int i = 0; i < vec[v].nb; i++) send_byte(vec[v].pkt[i]);
        if (vec[v].exp_rep != 8'h00) wait_reply(4);
        else repeat (30) @(negedge clk);
        chk($sformatf("v%0d_pktdone", v), n_done, {31'd0, vec[v].exp_done});
        chk($sformatf("v%0d_csumerr", v), n_cerr, {31'd0, vec[v].exp_cerr});
        chk($sformatf("v%0d_timeout", v), n_to, 0);
        chk($sformatf("v%0d_cmd", v), {24'd0, done_cmd}, {24'd0, vec[v].exp_cmd});
        chk($sformatf("v%0d_len", v), {16'd0, done_len}, {16'd0, vec[v].exp_len});
        chk($sformatf("v%0d_strobe_cyc", v), done_cyc, cap_cyc);
        chk($sformatf("v%0d_nvalid", v), rx_bytes.size(), vec[v].exp_nval);
        for (int i = 0; i < vec[v].exp_nval; i++) begin
            chk($sformatf("v%0d_payload%0d", v, i),
                (i < rx_bytes.size()) ? {24'd0, rx_bytes[i]} : 32'hDEAD,
                {24'd0, vec[v].pkt[4 + i]});
        end
        if (vec[v].exp_rep != 8'h00) chk_reply($sformatf("v%0d", v), vec[v].exp_rep);
        else chk($sformatf("v%0d_no_reply", v), tx_q.size(), 0);
    endtask

    initial begin
        int k;
        vec[0]  = '{pkt: {8'h23, 8'h68, 8'h00, 8'h00, 64'h0}, nb: 4, exp_done: 1, exp_cerr: 0,
                    exp_cmd: 8'h68, exp_len: 16'h0000, exp_nval: 0, exp_rep: 8'h56};
        vec[1]  = '{pkt: {8'h23, 8'h15, 8'h03, 8'h00, 8'h01, 8'h02, 8'h03, 8'h06, 8'h00, 24'h0},
                    nb: 9, exp_done: 1, exp_cerr: 0, exp_cmd: 8'h15, exp_len: 16'h0003,
                    exp_nval: 3, exp_rep: 8'h56};
        vec[2]  = '{pkt: {8'h23, 8'h15, 8'h03, 8'h00, 8'h01, 8'h02, 8'h03, 8'h07, 8'h00, 24'h0},
                    nb: 9, exp_done: 0, exp_cerr: 1, exp_cmd: 8'h15, exp_len: 16'h0003,
                    exp_nval: 3, exp_rep: 8'h5A};
        vec[3]  = '{pkt: {8'h23, 8'h56, 8'h00, 8'h00, 64'h0}, nb: 4, exp_done: 1, exp_cerr: 0,
                    exp_cmd: 8'h56, exp_len: 16'h0000, exp_nval: 0, exp_rep: 8'h00};
        vec[4]  = '{pkt: {8'h23, 8'h68, 8'h00, 8'h00, 64'h0}, nb: 4, exp_done: 1, exp_cerr: 0,
                    exp_cmd: 8'h68, exp_len: 16'h0000, exp_nval: 0, exp_rep: 8'h56};
        vec[5]  = '{pkt: {8'h23, 8'h92, 8'h00, 8'h00, 64'h0}, nb: 4, exp_done: 1, exp_cerr: 0,
                    exp_cmd: 8'h92, exp_len: 16'h0000, exp_nval: 0, exp_rep: 8'h56};
        vec[6]  = '{pkt: {8'h23, 8'h06, 8'h00, 8'h00, 64'h0}, nb: 4, exp_done: 1, exp_cerr: 0,
                    exp_cmd: 8'h06, exp_len: 16'h0000, exp_nval: 0, exp_rep: 8'h00};
        vec[7]  = '{pkt: {8'h23, 8'h06, 8'h02, 8'h00, 8'hFF, 8'hFF, 8'hFE, 8'h01, 32'h0},
                    nb: 8, exp_done: 1, exp_cerr: 0, exp_cmd: 8'h06, exp_len: 16'h0002,
                    exp_nval: 2, exp_rep: 8'h56};
        vec[8]  = '{pkt: {8'h23, 8'h09, 8'h05, 8'h00, 64'h0}, nb: 4, exp_done: 1, exp_cerr: 0,
                    exp_cmd: 8'h09, exp_len: 16'h0005, exp_nval: 0, exp_rep: 8'h00};
        vec[9]  = '{pkt: {8'h23, 8'hC9, 8'h01, 8'h00, 8'hAA, 8'hAA, 8'h00, 40'h0},
                    nb: 7, exp_done: 1, exp_cerr: 0, exp_cmd: 8'hC9, exp_len: 16'h0001,
                    exp_nval: 1, exp_rep: 8'h56};
        vec[10] = '{pkt: {8'h23, 8'h15, 8'h01, 8'h00, 8'h10, 8'h10, 8'h01, 40'h0},
                    nb: 7, exp_done: 0, exp_cerr: 1, exp_cmd: 8'h15, exp_len: 16'h0001,
                    exp_nval: 1, exp_rep: 8'h5A};

        i_reset_n = 1'b0;
        i_rxdata  = 8'h00;
        i_rxavail = 1'b0;
        clear_obs();
        repeat (3) @(negedge clk);
        chk("rst_rxread", {31'd0, o_rxread}, 32'd0);
        chk("rst_txenable", {31'd0, o_txenable}, 32'd0);
        chk("rst_txdata", {24'd0, o_txdata}, 32'd0);
        chk("rst_byte", {24'd0, o_byte}, 32'd0);
        chk("rst_bytevalid", {31'd0, o_bytevalid}, 32'd0);
        chk("rst_cmd", {24'd0, o_cmd}, 32'd0);
        chk("rst_len", {16'd0, o_len}, 32'd0);
        chk("rst_strobes", {29'd0, o_pktdone, o_csumerr, o_timeout}, 32'd0);
        i_reset_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int v = 0; v < 11; v++) run_vec(v);

        // abandoned partial packet, then a clean RDY
        clear_obs();
        send_byte(8'h23); send_byte(8'h15); send_byte(8'h05); send_byte(8'h00); send_byte(8'h01);
        k = 0;
        while (n_to == 0 && k < 300) begin
            @(negedge clk);
            k++;
        end
        chk("to_strobe", n_to, 1);
        chk("to_delay", to_cyc - cap_cyc, 100);
        chk("to_no_done", n_done + n_cerr, 0);
        chk("to_no_reply", tx_q.size(), 0);
        repeat (5) @(negedge clk);
        run_vec(0);

        // busy held at reply entry while the next packet is already waiting
        clear_obs();
        n_en_hold = 0; n_rd_early = 0;
        hold_busy = 1'b1;
        send_byte(8'h23); send_byte(8'h68); send_byte(8'h00); send_byte(8'h00);
        @(negedge clk);
        i_rxdata  = 8'h23;
        i_rxavail = 1'b1;
        watch_rx  = 1'b1;
        repeat (50) @(negedge clk);
        chk("hold_no_txen", n_en_hold, 0);
        chk("hold_no_tx", tx_q.size(), 0);
        chk("hold_pktdone", n_done, 1);
        hold_busy = 1'b0;
        wait_reply(4);
        k = 0;
        while (rd_cyc < 0 && k < 50) begin
            @(negedge clk);
            k++;
        end
        chk("hold_rx_during_reply", n_rd_early, 0);
        chk("hold_capture_delay", rd_cyc - push_cyc, 3);
        chk_reply("hold", 8'h56);
        watch_rx  = 1'b0;
        i_rxavail = 1'b0;
        k = 0;
        while (o_rxread && k < 50) begin
            @(negedge clk);
            k++;
        end
        tx_q.delete();
        n_done = 0;
        send_byte(8'h68); send_byte(8'h00); send_byte(8'h00);
        wait_reply(4);
        chk("hold_next_pktdone", n_done, 1);
        chk_reply("hold_next", 8'h56);

        // reset in the middle of a reply
        clear_obs();
        send_byte(8'h23); send_byte(8'h68); send_byte(8'h00); send_byte(8'h00);
        k = 0;
        while (!o_txenable && k < 100) begin
            @(negedge clk);
            k++;
        end
        chk("mid_reply_txen_seen", {31'd0, o_txenable}, 32'd1);
        #2;
        i_reset_n = 1'b0;
        #1;
        chk("async_rst_txen", {31'd0, o_txenable}, 32'd0);
        chk("async_rst_cmd", {24'd0, o_cmd}, 32'd0);
        @(negedge clk);
        i_reset_n = 1'b1;
        repeat (10) @(negedge clk);
        run_vec(1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
